// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, default timing constants, command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RTS       = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_tx_state_t;

  localparam int DEF_INHIBIT_CYCLES = 1250;    // 100 us at 12.5 MHz
  localparam int DEF_TIMEOUT_CYCLES = 187500;  // 15 ms at 12.5 MHz
  localparam int DEF_FILTER_LEN     = 4;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus glitch filter for one PS/2 line; output idles high.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // A new level is accepted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= 2'b11;
      cnt  <= '0;
      filt <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt  <= '0;
        filt <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter (RTS, 8 data + odd parity, stop, ack).
// Optional macro PS2_TX_ACK_CHECK_EN: a missing device ack reports err instead of done.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_t state;
  logic [8:0]    shreg;
  logic [3:0]    bitcnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic          clk_filt;
  logic          data_filt;
  logic          clk_filt_q;
  logic          fall;
  logic          timeout;
  logic          ack_ok;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .reset(reset), .raw(ps2clk_in), .filt(clk_filt)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk(clk), .reset(reset), .raw(ps2data_in), .filt(data_filt)
  );

  assign fall    = clk_filt_q & ~clk_filt;
  assign timeout = !fall && (to_cnt == TO_LAST) &&
                   (state == ST_SHIFT || state == ST_ACK || state == ST_WAIT_IDLE);

`ifdef PS2_TX_ACK_CHECK_EN
  assign ack_ok = ~data_filt;
`else
  assign ack_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      inh_cnt    <= '0;
      to_cnt     <= '0;
      clk_filt_q <= 1'b1;
      ps2clk_oe  <= 1'b0;
      ps2data_oe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      clk_filt_q <= clk_filt;
      done       <= 1'b0;
      err        <= 1'b0;
      if (timeout) begin
        err        <= 1'b1;
        busy       <= 1'b0;
        ps2clk_oe  <= 1'b0;
        ps2data_oe <= 1'b0;
        state      <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              shreg      <= {~^data, data};
              inh_cnt    <= '0;
              ps2clk_oe  <= 1'b1;
              ps2data_oe <= 1'b0;
              busy       <= 1'b1;
              state      <= ST_INHIBIT;
            end
          end
          // Device clock activity here is ignored: the host holds the line low.
          ST_INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
              ps2data_oe <= 1'b1;
              state      <= ST_RTS;
            end else begin
              inh_cnt <= inh_cnt + 1'b1;
            end
          end
          ST_RTS: begin
            ps2clk_oe <= 1'b0;
            bitcnt    <= '0;
            to_cnt    <= '0;
            state     <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (fall) begin
              to_cnt <= '0;
              bitcnt <= bitcnt + 1'b1;
              if (bitcnt == 4'd9) begin
                ps2data_oe <= 1'b0;
                state      <= ST_ACK;
              end else begin
                ps2data_oe <= ~shreg[0];
                shreg      <= {1'b0, shreg[8:1]};
              end
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          ST_ACK: begin
            if (fall) begin
              to_cnt <= '0;
              if (ack_ok) begin
                state <= ST_WAIT_IDLE;
              end else begin
                err        <= 1'b1;
                busy       <= 1'b0;
                ps2clk_oe  <= 1'b0;
                ps2data_oe <= 1'b0;
                state      <= ST_IDLE;
              end
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          ST_WAIT_IDLE: begin
            if (clk_filt && data_filt) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else if (fall) begin
              to_cnt <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte, such as 0xED for set-LEDs or 0xF4 for enable, from the FPGA to the keyboard. It sits beside the existing PS/2 receiver on the clkdiv4 domain (12.5 MHz) and shares the same ps2clk/ps2data lines through open-drain enables. It runs the full request-to-send, bit-shift, stop and acknowledge sequence, and reports completion or error to the command source.

## Interface
- INHIBIT_CYCLES, 1250: ps2clk hold-low time before request-to-send (100 µs at 12.5 MHz).
- TIMEOUT_CYCLES, 187500: maximum gap between device clock falling edges, and from clock release to the first edge (15 ms).
- FILTER_LEN, 4: consecutive equal synchronized samples required to accept a new line level.
- clk  in  1  block clock, clkdiv4.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only while busy=0.
- data  in  8  command byte, captured on an accepted start.
- ps2clk_in  in  1  raw PS/2 clock line.
- ps2data_in  in  1  raw PS/2 data line.
- ps2clk_oe  out  1  1 = drive ps2clk low, 0 = release.
- ps2data_oe  out  1  1 = drive ps2data low, 0 = release.
- busy  out  1  high from the cycle after an accepted start until the cycle done or err pulses.
- done  out  1  one-cycle pulse on successful transfer.
- err  out  1  one-cycle pulse on timeout or missing ack.

## Operation
- Input conditioning:
  - 2-flop synchronizer, then a FILTER_LEN glitch filter on each line.
  - fall = filtered ps2clk goes 1→0.
- Shift register: 9 bits, {odd parity, data}, loaded on an accepted start. Parity = ~^data.
- Bit counter: 4 bits.
- States and transitions:
  - IDLE: both oe = 0. start → INHIBIT, capture byte.
  - INHIBIT: clk_oe = 1 for INHIBIT_CYCLES cycles → RTS.
  - RTS: clk_oe = 1 and data_oe = 1 for exactly 1 cycle. This asserts the start bit → SHIFT. Clear the bit counter and the timeout counter.
  - SHIFT: clk_oe = 0. On each fall, data_oe = ~shreg[0], shift right, increment the counter.
    - Falls 1–8 present d0–d7, LSB first.
    - Fall 9 presents parity.
    - Fall 10 → data_oe = 0 (stop bit, released), go to ACK.
  - ACK: on the next fall, sample filtered ps2data. 0 → WAIT_IDLE; 1 → err path.
  - WAIT_IDLE: wait until both filtered lines are 1 → pulse done, go to IDLE.
- Timeout:
  - The counter runs in SHIFT, ACK and WAIT_IDLE, and clears on every fall.
  - On reaching TIMEOUT_CYCLES: pulse err, force both oe = 0, go to IDLE.
- ACK error path: pulse err, both oe = 0, go to IDLE. No automatic retry; the command source decides.
- start while busy = 1 is ignored, with no queueing.
- If the device drives the clock during INHIBIT, it is ignored. The host wins by holding the clock low.

## Timing
- Reset: ps2clk_oe = 0, ps2data_oe = 0, busy = 0, done = 0, err = 0, state = IDLE, counters 0. Reset mid-transfer releases both lines on the asynchronous assertion.
- start accepted in cycle N: busy = 1 and clk_oe = 1 in cycle N+1.
- Release of ps2clk occurs INHIBIT_CYCLES + 1 cycles after N+1.
- Edge latency: data_oe updates 2 + FILTER_LEN + 1 cycles after a raw ps2clk falling edge. This is well within the device low phase (≥ 30 µs, ≥ 375 cycles).
- done or err is high for exactly 1 cycle. busy falls in that same cycle.
- A new start is accepted in the cycle after done or err.

## Configuration
- PS2_TX_ACK_CHECK_EN defined: ACK state as above. A missing ack (data = 1 at fall 11) gives err.
- PS2_TX_ACK_CHECK_EN undefined: the fall-11 sample is ignored, and the block always proceeds to WAIT_IDLE. A timeout still gives err.

## Structure
- Shared package ps2_pkg:
  - state enum (IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE).
  - default INHIBIT_CYCLES and TIMEOUT_CYCLES constants.
  - command byte constants: CMD_SET_LEDS = 8'hED, CMD_ENABLE = 8'hF4, CMD_RESET = 8'hFF.
- Sub-module ps2_line_filter: synchronizer plus glitch filter, one instance per line. The receiver can reuse it.

## Test plan
- start with data = 0xED, device model clocking at 12.5 kHz and acking → bits on falls 1–9 are 1,0,1,1,0,1,1,1 and parity 1. data_oe = 0 from fall 10. done pulses once and busy drops in the same cycle.
- data = 0xF4 → bits 0,0,1,0,1,1,1,1 and parity 0. Check that clk_oe is high for exactly 1250 cycles plus 1 RTS cycle with data_oe = 1.
- Device never clocks after release → err pulses TIMEOUT_CYCLES cycles after clock release. Both oe = 0, busy = 0.
- Device holds data high at fall 11:
  - with PS2_TX_ACK_CHECK_EN → err;
  - without it → done.
- start pulsed again during SHIFT with a different data value → ignored; the transmitted byte is unchanged.
- reset asserted during SHIFT at fall 5 → oe outputs 0 immediately. After reset release, a fresh start of 0xFF completes with done.
- 1-cycle glitches on ps2clk_in during SHIFT → no extra shifts; the byte is still transmitted correctly.
